image_writer: RTL and testbench

IMAGE_WRITER -- requirements
Module: image_writer

---
 rtl/image_writer.sv | 175 +++++++++++++++++
 tb/tb_image_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_writer.sv
`default_nettype none
// ============================================================================
// Module      : image_writer
// Description : Streams 8-bit pixel bytes from a valid/ready source into a
//               32-bit data memory. Four consecutive bytes are packed
//               little-endian into one word, and each completed word is
//               issued as a single-cycle write at base_addr + ADDR_STEP*k.
//               A short final word is written with its unfilled lanes zero.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_STEP   byte-address increment between consecutive memory words
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   start       one-cycle frame-load request, honoured only when idle
//   abort       cancels a load in progress
//   base_addr   byte address of the first word (captured on start)
//   num_pixels  frame length in bytes (captured on start)
//   in_valid    source presents a byte on in_data
//   in_data     pixel byte
//   in_ready    block will accept a byte this cycle
//   mem_we      one-cycle memory write strobe
//   mem_addr    write byte address, valid with mem_we
//   mem_wdata   packed write word, valid with mem_we
//   busy        a frame load is in progress or completing
//   done        one-cycle completion pulse
//   wr_count    words written since the last accepted start
// ============================================================================
module image_writer #(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] base_addr,
    input  logic [16:0] num_pixels,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic [16:0] wr_count
);

    localparam logic [31:0] C_ADDR_STEP = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [16:0] r_num;        // captured frame length
    logic [16:0] r_pix_cnt;    // bytes accepted so far in this frame
    logic [1:0]  r_lane;       // byte lane the next accepted byte fills
    logic [23:0] r_pack;       // lanes 0..2 of the word being assembled
    logic [31:0] r_next_addr;  // address the next completed word goes to

    logic [31:0] w_word;
    logic        w_last;
    logic        w_flush;

    // Merge the incoming byte into the partial word. r_pack is cleared at
    // every word boundary, so lanes above the current one are always zero,
    // which also gives the zero-filled tail on a short final word.
    always_comb begin
        w_word = {8'd0, r_pack} | ({24'd0, in_data} << {r_lane, 3'b000});
    end

    // Extended by one bit so a frame of the maximum 17-bit length compares
    // correctly on its last byte.
    assign w_last  = (({1'b0, r_pix_cnt} + 18'd1) == {1'b0, r_num});
    assign w_flush = (r_lane == 2'd3) || w_last;

    // The packing registers (r_pack/r_lane) are separate from the memory
    // output registers, so a completed word moves to mem_* on the same edge
    // the next word starts filling and the source is never stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_num       <= 17'd0;
            r_pix_cnt   <= 17'd0;
            r_lane      <= 2'd0;
            r_pack      <= 24'd0;
            r_next_addr <= 32'd0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_count    <= 17'd0;
        end else begin
            // Write strobe is a single-cycle pulse; mem_addr/mem_wdata hold.
            mem_we <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_num       <= num_pixels;
                        r_next_addr <= base_addr;
                        r_pix_cnt   <= 17'd0;
                        r_lane      <= 2'd0;
                        r_pack      <= 24'd0;
                        wr_count    <= 17'd0;
                        busy        <= 1'b1;
                        if (num_pixels != 17'd0) begin
                            r_state  <= ST_RUN;
                            in_ready <= 1'b1;
                        end else begin
                            // Empty frame: complete without any write.
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        // Abort wins over a same-cycle transfer; the partial
                        // word is dropped. A write launched on the previous
                        // edge is already on mem_* and finishes untouched.
                        r_state  <= ST_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        r_lane   <= 2'd0;
                        r_pack   <= 24'd0;
                    end else if (in_valid) begin
                        r_pix_cnt <= r_pix_cnt + 17'd1;
                        if (w_flush) begin
                            mem_we      <= 1'b1;
                            mem_addr    <= r_next_addr;
                            mem_wdata   <= w_word;
                            r_next_addr <= r_next_addr + C_ADDR_STEP;
                            wr_count    <= wr_count + 17'd1;
                            r_lane      <= 2'd0;
                            r_pack      <= 24'd0;
                        end else begin
                            r_pack <= w_word[23:0];
                            r_lane <= r_lane + 2'd1;
                        end
                        if (w_last) begin
                            // The final write lands in the DONE cycle,
                            // together with the done pulse.
                            r_state  <= ST_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_writer
// Description : Directed self-checking bench for image_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [16:0] num_pixels;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [16:0] wr_count;

    always #5 clk = ~clk;

    image_writer #(.ADDR_STEP(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .num_pixels (num_pixels),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Passive monitor, sampling on the falling edge
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] wc_q[$];
    int          wcyc_q[$];
    int          wdone_q[$];
    int          acc_q[$];
    int          done_q[$];
    int          ready_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(32'(wr_count));
            wcyc_q.push_back(cyc);
            wdone_q.push_back(int'(done));
        end
        // A byte visible here transfers on the next rising edge.
        if (in_valid && in_ready && !abort && !reset) acc_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        // busy && !done identifies RUN
        if (busy && !done && !in_ready) ready_low++;
    end

    logic [7:0] pix [0:7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        wcyc_q.delete(); wdone_q.delete(); acc_q.delete(); done_q.delete();
    endtask

    // Start a frame and stream its bytes. gap=1 idles in_valid every
    // other cycle; start_at>=0 pulses a conflicting start at that byte.
    task automatic run_frame(input logic [31:0] base, input logic [16:0] n,
                             input int gap, input int start_at);
        int i;
        int guard;
        bit tog;
        clear_mon();
        start = 1'b1; base_addr = base; num_pixels = n;
        step();
        start = 1'b0;
        i = 0; guard = 0; tog = 1'b0;
        while (i < int'(n) && guard < 100) begin
            in_valid = (gap != 0) ? !tog : 1'b1;
            in_data  = pix[i];
            if (i == start_at && in_valid) begin
                start = 1'b1; base_addr = 32'h0000_5000; num_pixels = 17'd2;
            end
            step();
            start = 1'b0;
            if (in_valid) i++;
            tog = !tog;
            guard++;
        end
        if (guard >= 100) check("frame_timeout", 32'(i), 32'(n));
        in_valid = 1'b0;
        repeat (3) step();
    endtask

    // Checks for a two-word frame; last_idx is the frame's final byte index.
    task automatic check_two(input logic [31:0] a0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [31:0] d1,
                             input int last_idx);
        check("nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("addr0", wa_q[0], a0);
            check("data0", wd_q[0], d0);
            check("addr1", wa_q[1], a1);
            check("data1", wd_q[1], d1);
            check("done_w0", 32'(wdone_q[0]), 32'd0);
            check("done_w1", 32'(wdone_q[1]), 32'd1);
            check("cnt_w0", wc_q[0], 32'd1);
            check("cnt_w1", wc_q[1], 32'd2);
            if (acc_q.size() > last_idx) begin
                check("lat_w0", 32'(wcyc_q[0]), 32'(acc_q[3] + 1));
                check("lat_w1", 32'(wcyc_q[1]), 32'(acc_q[last_idx] + 1));
            end else begin
                check("nbytes", 32'(acc_q.size()), 32'(last_idx + 1));
            end
        end
        check("ndone", 32'(done_q.size()), 32'd1);
        check("final_cnt", 32'(wr_count), 32'd2);
        check("idle_busy", 32'(busy), 32'd0);
        check("hold_addr", mem_addr, a1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = 32'd0;
        num_pixels = 17'd0; in_valid = 1'b0; in_data = 8'd0;
        repeat (2) step();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we",    32'(mem_we),   32'd0);
        check("rst_addr",  mem_addr,      32'd0);
        check("rst_data",  mem_wdata,     32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_cnt",   32'(wr_count), 32'd0);
        // Reset overrides a simultaneous start.
        start = 1'b1; num_pixels = 17'd8;
        step();
        start = 1'b0; reset = 1'b0;
        step();
        check("rst_vs_start", 32'(busy), 32'd0);

        // Eight bytes back to back.
        for (int k = 0; k < 8; k++) pix[k] = 8'(k + 1);
        run_frame(32'h0000_1000, 17'd8, 0, -1);
        check_two(32'h0000_1000, 32'h0403_0201, 32'h0000_1004, 32'h0807_0605, 7);

        // Short last word.
        pix[0] = 8'hAA; pix[1] = 8'hBB; pix[2] = 8'hCC; pix[3] = 8'hDD; pix[4] = 8'hEE;
        run_frame(32'h0000_0200, 17'd5, 0, -1);
        check_two(32'h0000_0200, 32'hDDCC_BBAA, 32'h0000_0204, 32'h0000_00EE, 4);

        // Same eight bytes with a bubble every other cycle.
        for (int k = 0; k < 8; k++) pix[k] = 8'(k + 1);
        run_frame(32'h0000_1000, 17'd8, 1, -1);
        check_two(32'h0000_1000, 32'h0403_0201, 32'h0000_1004, 32'h0807_0605, 7);

        // A start arriving during RUN must not disturb the frame.
        for (int k = 0; k < 8; k++) pix[k] = 8'(8'h11 + k);
        run_frame(32'h0000_2000, 17'd8, 0, 2);
        check_two(32'h0000_2000, 32'h1413_1211, 32'h0000_2004, 32'h1817_1615, 7);

        // Abort with the third byte offered.
        clear_mon();
        start = 1'b1; base_addr = 32'h0000_4000; num_pixels = 17'd8;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; step();
        in_data = 8'h02; step();
        in_data = 8'h03; abort = 1'b1; step();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_busy",  32'(busy),     32'd0);
        check("abort_cnt",   32'(wr_count), 32'd0);
        repeat (4) step();
        check("abort_writes", 32'(wa_q.size()),   32'd0);
        check("abort_done",   32'(done_q.size()), 32'd0);
        // A fresh frame afterwards works normally.
        for (int k = 0; k < 8; k++) pix[k] = 8'(k + 1);
        run_frame(32'h0000_1000, 17'd8, 0, -1);
        check_two(32'h0000_1000, 32'h0403_0201, 32'h0000_1004, 32'h0807_0605, 7);

        // Zero-length frame.
        clear_mon();
        start = 1'b1; num_pixels = 17'd0; base_addr = 32'h0000_7000;
        step();
        start = 1'b0;
        check("zero_done",  32'(done),   32'd1);
        check("zero_busy",  32'(busy),   32'd1);
        check("zero_ready", 32'(in_ready), 32'd0);
        step();
        check("zero_done_off", 32'(done), 32'd0);
        check("zero_idle",     32'(busy), 32'd0);
        check("zero_writes",   32'(wa_q.size()), 32'd0);
        check("zero_cnt",      32'(wr_count), 32'd0);

        // Reset after six of eight bytes.
        clear_mon();
        start = 1'b1; base_addr = 32'h0000_3000; num_pixels = 17'd8;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h21 + k);
            step();
        end
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_we",    32'(mem_we),   32'd0);
        check("mid_rst_addr",  mem_addr,      32'd0);
        check("mid_rst_data",  mem_wdata,     32'd0);
        check("mid_rst_busy",  32'(busy),     32'd0);
        check("mid_rst_cnt",   32'(wr_count), 32'd0);
        repeat (4) step();
        check("mid_rst_writes", 32'(wa_q.size()), 32'd1);
        check("mid_rst_done",   32'(done_q.size()), 32'd0);

        // Address wrap-around.
        for (int k = 0; k < 8; k++) pix[k] = 8'(k + 1);
        run_frame(32'hFFFF_FFFC, 17'd8, 0, -1);
        check_two(32'hFFFF_FFFC, 32'h0403_0201, 32'h0000_0000, 32'h0807_0605, 7);

        check("ready_in_run", 32'(ready_low), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
